// File: rtl/dmem_dump_ctrl.sv
// Data-memory port controller: shares the CPU data-memory port with an engine that streams every word out over valid/ready.
// Optional feature: define DMEM_DUMP_CHECKSUM_EN to build the running dump_sum accumulator (otherwise dump_sum is tied to 0).
module dmem_dump_ctrl #(
    parameter int N     = 64,
    parameter int DEPTH = 64
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         dump,
    input  logic [N-1:0] cpu_addr,
    input  logic [N-1:0] cpu_wdata,
    input  logic         cpu_we,
    output logic [N-1:0] cpu_rdata,
    output logic         cpu_stall,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_we,
    input  logic [N-1:0] mem_rdata,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [N-1:0] dump_addr,
    output logic [N-1:0] dump_data,
    output logic         dump_busy,
    output logic         dump_done,
    output logic [N-1:0] dump_sum
);
    localparam int            IW       = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           dump_q;
    logic [IW-1:0]  idx_q, idx_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   data_q, data_d;
    logic [N-1:0]   addr_q, addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           stall_q, stall_d;
    logic           trigger_s, load_s, xfer_s;
    logic [N-1:0]   idx_addr_s;

    // Handshake qualifiers and the byte address of the word being fetched.
    always_comb begin
        trigger_s  = dump & ~dump_q;
        load_s     = ~valid_q | dump_ready;
        xfer_s     = valid_q & dump_ready;
        idx_addr_s = {{(N-IW-3){1'b0}}, idx_q, 3'b000};
    end

    // Next-state logic for the dump sequencer and the presented word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        stall_d = stall_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger_s) begin
                    state_d = S_READ;
                    idx_d   = {IW{1'b0}};
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    stall_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // A new word may replace the old one in the same cycle it is accepted.
                if (load_s) begin
                    data_d  = mem_rdata;
                    addr_d  = idx_addr_s;
                    valid_d = 1'b1;
                    idx_d   = idx_q + IW'(1'b1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_FLUSH: begin
                if (xfer_s) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                stall_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                stall_d = 1'b0;
            end
        endcase
    end

    // Memory port ownership: CPU pass-through in IDLE, dump engine otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            cpu_rdata = mem_rdata;
        end else begin
            mem_addr  = idx_addr_s;
            mem_wdata = {N{1'b0}};
            mem_we    = 1'b0;
            cpu_rdata = {N{1'b0}};
        end
    end

    // Sequencer and presented-word registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dump_q  <= 1'b0;
            idx_q   <= {IW{1'b0}};
            valid_q <= 1'b0;
            data_q  <= {N{1'b0}};
            addr_q  <= {N{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dump_q  <= dump;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stall_q <= stall_d;
        end
    end

    assign cpu_stall  = stall_q;
    assign dump_valid = valid_q;
    assign dump_data  = data_q;
    assign dump_addr  = addr_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [N-1:0] sum_q, sum_d;

    // Checksum: cleared on trigger, accumulates each accepted word, held afterwards.
    always_comb begin
        if ((state_q == S_IDLE) && trigger_s) begin
            sum_d = {N{1'b0}};
        end else if (xfer_s) begin
            sum_d = sum_q + data_q;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sum_q <= {N{1'b0}};
        end else begin
            sum_q <= sum_d;
        end
    end

    assign dump_sum = sum_q;
`else
    assign dump_sum = {N{1'b0}};
`endif

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Randomized bench for dmem_dump_ctrl: a behavioural memory plus a snapshot/queue reference model of the dump stream.
module tb_dmem_dump_ctrl;
    localparam int N     = 64;
    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         dump;
    logic [N-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_we, cpu_stall;
    logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_we;
    logic         dump_valid, dump_ready, dump_busy, dump_done;
    logic [N-1:0] dump_addr, dump_data, dump_sum;

    logic [N-1:0] mem_m [DEPTH];
    int           n_chk  = 0;
    int           n_pass = 0;

    dmem_dump_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .dump       (dump),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_sum   (dump_sum)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we) mem_m[mem_addr[8:3]] <= mem_wdata;
    end
    assign mem_rdata = mem_m[mem_addr[8:3]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cpu_store(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    // mode: 0 ready always high, 1 ready dropped 3 cycles on word 5, 2 random ready.
    // abort_at >= 0 asserts reset once that many words have been accepted.
    task automatic run_dump(input int mode, input int abort_at, input bit trig_wr);
        logic [63:0] snap [DEPTH];
        logic [63:0] esum, trig_val, hd, ha;
        int          k, c, stalls, hold_cnt, nbad;
        bit          held;
        @(negedge clk);
        dump = 1'b0; cpu_we = 1'b0; dump_ready = 1'b0;
        @(negedge clk);
        dump = 1'b1;
        trig_val = {$urandom, $urandom};
        cpu_we = trig_wr; cpu_addr = 64'h20; cpu_wdata = trig_val;
        @(posedge clk); #1;
        chk("stall_e0", {63'd0, cpu_stall}, 64'd1);
        chk("busy_e0", {63'd0, dump_busy}, 64'd1);
        if (trig_wr) chk("trig_wr", mem_m[4], trig_val);
        snap = mem_m;
        esum = 64'd0;
        for (int i = 0; i < DEPTH; i++) esum += snap[i];
        k = 0; c = 0; stalls = 0; hold_cnt = 0; held = 1'b0;
        while (1) begin
            @(negedge clk);
            case (mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = !(dump_valid && k == 5 && hold_cnt < 3);
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            dump      = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 64'($urandom_range(0, DEPTH - 1)) << 3;
            cpu_wdata = 64'hFF;
            #1;
            if (abort_at >= 0 && k == abort_at) begin
                rst = 1'b1; dump = 1'b0; cpu_we = 1'b0;
                #1;
                chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
                chk("rst_busy", {63'd0, dump_busy}, 64'd0);
                chk("rst_valid", {63'd0, dump_valid}, 64'd0);
                chk("rst_done", {63'd0, dump_done}, 64'd0);
                chk("rst_data", dump_data, 64'd0);
                chk("rst_addr", dump_addr, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (held) begin
                chk("hold_data", dump_data, hd);
                chk("hold_addr", dump_addr, ha);
            end
            if (cpu_we) chk("we_blocked", {63'd0, mem_we}, 64'd0);
            if (dump_done) begin
                chk("done_cycle", 64'(c), 64'(DEPTH + 1 + stalls));
                chk("n_words", 64'(k), 64'(DEPTH));
                chk("stall_at_done", {63'd0, cpu_stall}, 64'd1);
`ifdef DMEM_DUMP_CHECKSUM_EN
                chk("sum", dump_sum, esum);
`else
                chk("sum", dump_sum, 64'd0);
`endif
                if (mode == 1) chk("ready_gaps", 64'(stalls), 64'd3);
                break;
            end
            chk("stall_busy", {63'd0, cpu_stall}, 64'd1);
            if (dump_valid && dump_ready) begin
                if (k < DEPTH) begin
                    chk("word_data", dump_data, snap[k]);
                    chk("word_addr", dump_addr, 64'(k) << 3);
                end else begin
                    chk("extra_word", 64'(k), 64'(DEPTH - 1));
                end
                k++;
                held = 1'b0;
            end else if (dump_valid) begin
                stalls++; hold_cnt++;
                held = 1'b1; hd = dump_data; ha = dump_addr;
            end else begin
                held = 1'b0;
            end
            if (c > 4000) begin
                chk("timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
            c++;
        end
        dump = 1'b1; cpu_we = 1'b0;
        @(negedge clk); #1;
        chk("release_stall", {63'd0, cpu_stall}, 64'd0);
        chk("release_busy", {63'd0, dump_busy}, 64'd0);
        chk("release_done", {63'd0, dump_done}, 64'd0);
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_m[i] !== snap[i]) nbad++;
        chk("mem_kept", 64'(nbad), 64'd0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("no_retrig", {63'd0, cpu_stall}, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; dump = 1'b0; dump_ready = 1'b0;
        cpu_we = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", {63'd0, cpu_stall}, 64'd0);
        chk("reset_valid", {63'd0, dump_valid}, 64'd0);
        chk("reset_busy", {63'd0, dump_busy}, 64'd0);
        chk("reset_done", {63'd0, dump_done}, 64'd0);
        chk("reset_sum", dump_sum, 64'd0);
        rst = 1'b0;

        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'hA5;
        #1;
        chk("pass_we", {63'd0, mem_we}, 64'd1);
        chk("pass_addr", mem_addr, 64'h10);
        chk("pass_wdata", mem_wdata, 64'hA5);
        chk("pass_stall", {63'd0, cpu_stall}, 64'd0);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        chk("pass_load", cpu_rdata, 64'hA5);

        for (int i = 0; i < DEPTH; i++) cpu_store(64'(i) << 3, 64'(i + 1));
        run_dump(0, -1, 1'b0);
`ifdef DMEM_DUMP_CHECKSUM_EN
        chk("sum_2080", dump_sum, 64'd2080);
`else
        chk("sum_off", dump_sum, 64'd0);
`endif
        run_dump(1, -1, 1'b1);
        for (int i = 0; i < DEPTH; i++) cpu_store(64'(i) << 3, {$urandom, $urandom});
        run_dump(2, -1, 1'b1);
        run_dump(0, 10, 1'b0);
        run_dump(2, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
